user_bram_wb: RTL and testbench
===============================

// Module: user_bram_wb
// PURPOSE
//  Wishbone classic slave memory for the user project area at 0x3800_0000 (mprjram).
//  Holds firmware code and data fetched or stored by the management core, e.g. matmul() executed in place.
//  Each access completes after a fixed, programmable delay, modelling slow off-chip memory.
//  Sits between the caravel user-area Wishbone port and an inferred single-port word RAM.
// PARAMETERS
//  ADDR_BASE  8'h38  required value of wbs_adr_i[31:24] for a hit
//  ADDR_W     10     word-address width; DEPTH = 2**ADDR_W 32-bit words (4 KiB)
//  DELAY      10     cycles from request acceptance to ack; legal range 1..255
// PORTS
//  clock      in   1   system clock; all logic on rising edge
//  resetb     in   1   asynchronous active-low reset
//  wbs_cyc_i  in   1   Wishbone bus cycle
//  wbs_stb_i  in   1   Wishbone strobe
//  wbs_we_i   in   1   1 = write, 0 = read
//  wbs_sel_i  in   4   byte lane enables; bit n covers dat[8n+7:8n]
//  wbs_adr_i  in   32  byte address
//  wbs_dat_i  in   32  write data
//  wbs_ack_o  out  1   one-cycle acknowledge
//  wbs_dat_o  out  32  read data, valid while wbs_ack_o is high
// BEHAVIOUR
//  - Reset (resetb=0, async): wbs_ack_o=0, wbs_dat_o=0, FSM=IDLE, delay counter=0. RAM contents are not cleared.
//  - hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24]==ADDR_BASE).
//  - Word index = wbs_adr_i[ADDR_W+1:2]. Bits [1:0] and bits [23:ADDR_W+2] are ignored,
//    so addresses above DEPTH alias (wrap) onto the RAM.
//  - FSM IDLE -> WAIT: in IDLE, a hit at a rising edge accepts the request.
//    Accept latches address, we, sel and data, and loads cnt=1.
//  - FSM WAIT: cnt increments each cycle.
//    When cnt==DELAY, go to ACK: wbs_ack_o=1 for exactly one cycle.
//    Net result: the ack is high in the cycle DELAY clocks after the accepting edge.
//  - DELAY=1: ack appears in the cycle right after acceptance.
//  - FSM ACK -> IDLE unconditionally. A hit present during the ACK cycle is not accepted;
//    at least one IDLE cycle separates transactions.
//  - Write: on entry to ACK, RAM[idx] is updated byte-wise where the latched sel bit is 1.
//    wbs_dat_o is unchanged.
//  - Read: on entry to ACK, wbs_dat_o <= RAM[idx] (full word; sel ignored).
//    wbs_dat_o holds until the next read ack.
//  - Abort: if cyc or stb drops while in WAIT, go to IDLE with no ack and no write.
//  - Reset mid-transaction: aborts immediately; no write occurs, no ack.
//  - Non-hit addresses never produce an ack and never touch RAM. The bus fabric owns the timeout.
//  - A read immediately after a write to the same word returns the new data.
// TESTING
//  1. Assert resetb=0 mid-WAIT -> wbs_ack_o=0 and wbs_dat_o=0 immediately; no RAM change (read back old value).
//  2. Write 0x12345678, sel=4'hF, to 0x3800_0000.
//     -> ack is a single pulse exactly 10 cycles after acceptance.
//     Reading the same address -> 0x12345678 after 10 cycles.
//  3. Write 0xAABBCCDD, sel=4'b0010, to 0x3800_0000; read back -> 0x1234CC78.
//  4. Strobe 0x3000_0000 for 50 cycles -> no ack; then read 0x3800_0000 -> still 0x1234CC78.
//  5. Write 0xDEADBEEF to 0x3800_1000 (alias) -> read 0x3800_0000 returns 0xDEADBEEF.
//     Back-to-back requests -> 1 idle cycle between acks.
//  6. Drop stb after 5 WAIT cycles of a write of 0x0 -> no ack; the word is unchanged.
//     System smoke: firmware runs matmul from 0x3800_0000 and reports results 0x003E, 0x0044, 0x004A, 0x0050 on mprj_io[31:16].

Source files
------------

// File: rtl/user_bram_wb.sv
// Wishbone classic slave word RAM for the user project area (mprjram window).
// Latency: ack is high in the cycle DELAY clocks after the accepting edge; one idle cycle between transactions.
// Backpressure: one request at a time; hits are ignored until the FSM is back in IDLE, and a dropped cyc/stb aborts.
module user_bram_wb #(
    parameter logic [7:0] ADDR_BASE = 8'h38,
    parameter int         ADDR_W    = 10,
    parameter int         DELAY     = 10
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o
);

    localparam int         DEPTH   = 2 ** ADDR_W;
    localparam logic [7:0] DELAY_C = 8'(DELAY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t              state;
    logic [7:0]          cnt;
    logic                we_q;
    logic [3:0]          sel_q;
    logic [31:0]         dat_q;
    logic [ADDR_W-1:0]   idx_q;

    logic                bus_req;
    logic                hit;
    logic [ADDR_W-1:0]   idx;
    logic                done;
    logic                ram_wr;

    // Word storage; never reset, contents survive resetb.
    logic [31:0]         mem [DEPTH];

    // Byte offset and the bits between the RAM index and the base compare
    // are don't-care: upper addresses alias onto the RAM.
    logic                unused_adr;
    assign unused_adr = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};

    // Address decode and transaction-completion qualifiers.
    always_comb begin
        bus_req = wbs_cyc_i & wbs_stb_i;
        hit     = bus_req & (wbs_adr_i[31:24] == ADDR_BASE);
        idx     = wbs_adr_i[ADDR_W+1:2];
        // Abort has priority over completion: a dropped strobe on the
        // final WAIT cycle still cancels the access.
        done    = (state == ST_WAIT) && bus_req && (cnt == DELAY_C);
        ram_wr  = done & we_q;
    end

    // Request FSM: latch on accept, count the delay, pulse ack, return to idle.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            we_q      <= 1'b0;
            sel_q     <= 4'd0;
            dat_q     <= 32'd0;
            idx_q     <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wbs_ack_o <= 1'b0;
                    if (hit) begin
                        we_q  <= wbs_we_i;
                        sel_q <= wbs_sel_i;
                        dat_q <= wbs_dat_i;
                        idx_q <= idx;
                        cnt   <= 8'd1;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!bus_req) begin
                        cnt   <= 8'd0;
                        state <= ST_IDLE;
                    end else if (done) begin
                        wbs_ack_o <= 1'b1;
                        state     <= ST_ACK;
                        if (!we_q) begin
                            wbs_dat_o <= mem[idx_q];
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_ACK: begin
                    // Any hit seen here is deliberately ignored; the
                    // next request is taken from IDLE.
                    wbs_ack_o <= 1'b0;
                    cnt       <= 8'd0;
                    state     <= ST_IDLE;
                end
                default: begin
                    wbs_ack_o <= 1'b0;
                    cnt       <= 8'd0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Byte-masked RAM write on the edge that enters ACK.
    always_ff @(posedge clock) begin
        if (ram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    mem[idx_q][8*b +: 8] <= dat_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_user_bram_wb.sv
// Directed bench for user_bram_wb: default DELAY=10 instance plus a DELAY=1 instance.
// Each step drives a Wishbone access and checks latency, pulse width and data.
// Both instances share the bus except for their individual strobes.
module tb_user_bram_wb;

    logic        clock;
    logic        resetb;
    logic        wbs_cyc_i;
    logic        stb0;
    logic        stb1;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        ack0;
    logic        ack1;
    logic [31:0] dat0;
    logic [31:0] dat1;

    int tests;
    int fails;

    user_bram_wb #(.ADDR_BASE(8'h38), .ADDR_W(10), .DELAY(10)) u_dut0 (
        .clock     (clock),
        .resetb    (resetb),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (stb0),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (ack0),
        .wbs_dat_o (dat0)
    );

    user_bram_wb #(.ADDR_BASE(8'h38), .ADDR_W(10), .DELAY(1)) u_dut1 (
        .clock     (clock),
        .resetb    (resetb),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (stb1),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (ack1),
        .wbs_dat_o (dat1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One Wishbone access on instance `which`. Returns read data and the
    // number of edges from the accepting edge to the ack (-1 on timeout).
    task automatic bus_op(input int which, input logic we, input logic [3:0] sel,
                          input logic [31:0] adr, input logic [31:0] wdat,
                          output logic [31:0] rdat, output int lat);
        logic a;
        lat       = -1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = we;
        wbs_sel_i = sel;
        wbs_adr_i = adr;
        wbs_dat_i = wdat;
        if (which == 0) stb0 = 1'b1; else stb1 = 1'b1;
        tick();                               // accepting edge
        for (int n = 1; n <= 300; n++) begin
            tick();
            a = (which == 0) ? ack0 : ack1;
            if (a) begin
                lat = n;
                break;
            end
        end
        rdat      = (which == 0) ? dat0 : dat1;
        stb0      = 1'b0;
        stb1      = 1'b0;
        wbs_cyc_i = 1'b0;
        tick();
        a = (which == 0) ? ack0 : ack1;
        check("ack_single_pulse", {31'd0, a}, 32'd0);
    endtask

    logic [31:0] rd;
    int          lat;
    int          nacks;

    initial begin
        tests     = 0;
        fails     = 0;
        resetb    = 1'b0;
        wbs_cyc_i = 1'b0;
        stb0      = 1'b0;
        stb1      = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_adr_i = 32'h0;
        wbs_dat_i = 32'h0;
        repeat (3) tick();
        check("reset_ack", {31'd0, ack0}, 32'd0);
        check("reset_dat", dat0, 32'd0);
        resetb = 1'b1;
        tick();

        // Full-word write and read-back with DELAY=10.
        bus_op(0, 1'b1, 4'hF, 32'h3800_0000, 32'h1234_5678, rd, lat);
        check("wr_latency", lat, 32'd10);
        check("wr_dat_unchanged", rd, 32'd0);
        bus_op(0, 1'b0, 4'hF, 32'h3800_0000, 32'h0, rd, lat);
        check("rd_latency", lat, 32'd10);
        check("rd_data", rd, 32'h1234_5678);

        // Reset in the middle of WAIT: outputs clear at once, no RAM write.
        wbs_cyc_i = 1'b1; stb0 = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3800_0000; wbs_dat_i = 32'hFFFF_FFFF;
        tick();
        repeat (4) tick();
        #2 resetb = 1'b0;
        #1;
        check("midreset_ack", {31'd0, ack0}, 32'd0);
        check("midreset_dat", dat0, 32'd0);
        wbs_cyc_i = 1'b0; stb0 = 1'b0;
        tick();
        resetb = 1'b1;
        tick();
        bus_op(0, 1'b0, 4'hF, 32'h3800_0000, 32'h0, rd, lat);
        check("midreset_ram_kept", rd, 32'h1234_5678);

        // Byte-lane write: only lane 1 updates.
        bus_op(0, 1'b1, 4'b0010, 32'h3800_0000, 32'hAABB_CCDD, rd, lat);
        check("sel_wr_latency", lat, 32'd10);
        bus_op(0, 1'b0, 4'hF, 32'h3800_0003, 32'h0, rd, lat);
        check("sel_rd_data", rd, 32'h1234_CC78);

        // Non-hit region strobed for 50 cycles: no ack, RAM untouched.
        nacks = 0;
        wbs_cyc_i = 1'b1; stb0 = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3000_0000; wbs_dat_i = 32'h5555_5555;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ack0) nacks++;
        end
        wbs_cyc_i = 1'b0; stb0 = 1'b0;
        tick();
        check("miss_no_ack", nacks, 32'd0);
        bus_op(0, 1'b0, 4'hF, 32'h3800_0000, 32'h0, rd, lat);
        check("miss_ram_kept", rd, 32'h1234_CC78);

        // Aliased address wraps onto word 0.
        bus_op(0, 1'b1, 4'hF, 32'h3800_1000, 32'hDEAD_BEEF, rd, lat);
        bus_op(0, 1'b0, 4'hF, 32'h3800_0000, 32'h0, rd, lat);
        check("alias_rd_data", rd, 32'hDEAD_BEEF);

        // Back-to-back with strobe held: next ack comes DELAY+2 edges later.
        bus_op(0, 1'b1, 4'hF, 32'h3800_0004, 32'h0BAD_F00D, rd, lat);
        wbs_cyc_i = 1'b1; stb0 = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3800_0004;
        lat = -1;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (ack0) break;
        end
        check("b2b_first_data", dat0, 32'h0BAD_F00D);
        tick();
        check("b2b_gap_ack_low", {31'd0, ack0}, 32'd0);
        for (int n = 2; n <= 300; n++) begin
            tick();
            if (ack0) begin
                lat = n;
                break;
            end
        end
        check("b2b_ack_spacing", lat, 32'd12);
        wbs_cyc_i = 1'b0; stb0 = 1'b0;
        tick();

        // Strobe dropped after 5 WAIT cycles: no ack, no write.
        nacks = 0;
        wbs_cyc_i = 1'b1; stb0 = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3800_0000; wbs_dat_i = 32'h0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ack0) nacks++;
        end
        stb0 = 1'b0; wbs_cyc_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack0) nacks++;
        end
        check("abort_no_ack", nacks, 32'd0);
        bus_op(0, 1'b0, 4'hF, 32'h3800_0000, 32'h0, rd, lat);
        check("abort_ram_kept", rd, 32'hDEAD_BEEF);

        // DELAY=1 instance: ack on the edge right after acceptance.
        bus_op(1, 1'b1, 4'b1001, 32'h3800_0010, 32'hA1B2_C3D4, rd, lat);
        check("d1_wr_latency", lat, 32'd1);
        bus_op(1, 1'b1, 4'b0110, 32'h3800_0010, 32'h1122_3344, rd, lat);
        bus_op(1, 1'b0, 4'h0, 32'h3800_0010, 32'h0, rd, lat);
        check("d1_rd_latency", lat, 32'd1);
        check("d1_rd_data", rd, 32'hA122_33D4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
